simd_sat_adder_pipe: RTL
========================

Name: simd_sat_adder_pipe

Overview:
Parametrised, two-stage pipelined successor to the ALU's 16-bit saturating adder. Supports full-width saturating ADD/SUB, lane-wise saturating packed add (PADDSB generalised to LANE-bit lanes), and signed reduction (RED) across all lanes of both operands. Sits between the EX operand muxes and the EX/MEM latch. Uses a valid/ready handshake so the pipeline can be stalled. Keeps a sticky saturation-event counter for debug and perf readout.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of LANE
LANE, 4, packed lane width in bits (≥2)
CNT_W, 8, width of saturation-event counter

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/op valid this cycle
in_ready  out  1  block can accept input this cycle
op  in  2  00 ADD, 01 SUB, 10 PADDSB, 11 RED
A  in  WIDTH  operand A (two's complement)
B  in  WIDTH  operand B (two's complement)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
S  out  WIDTH  result
ovfl  out  1  saturation/overflow occurred for this result
sat_cnt  out  CNT_W  count of accepted results with ovfl=1
cnt_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset (async, rst_n=0): stage valids=0, out_valid=0, S=0, ovfl=0, sat_cnt=0. In-flight ops are discarded; no partial result is ever presented. in_ready=1 after release.
- Handshake: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready. in_ready = ~s1_valid | s1_adv, where s1_adv = ~s2_valid | out_ready. Stage 2 is the output register. Held S/ovfl must stay stable while out_valid & ~out_ready. Throughput is 1 op/cycle with no bubbles under continuous out_ready.
- Latency: an op accepted at cycle t gives out_valid at t+2 if not stalled.
- Stage 1 registers op, the raw WIDTH-bit sum A+B (ADD/PADDSB) or A+~B+1 (SUB), and the per-lane raw sums with inter-lane carries suppressed for PADDSB. It also registers the operand sign bits (full-width and per-lane) needed for overflow detection.
- Stage 2 produces the result:
  - ADD/SUB: let b' = B (ADD) or ~B (SUB). Positive overflow when A and b' are both non-negative and the raw MSB is 1 → S=0x7FF..F. Negative overflow when both are negative and the raw MSB is 0 → S=0x800..0. Otherwise S=raw. ovfl=1 on either overflow.
  - PADDSB: each LANE-bit lane is added independently. Lane positive overflow → 0 followed by ones (0x7 for LANE=4); lane negative overflow → 1 followed by zeros (0x8). ovfl = OR of lane overflows.
  - RED: sign-extend every lane of A and of B and sum all 2·WIDTH/LANE values at full precision. Sign-extend the sum to WIDTH; it cannot overflow for WIDTH≥LANE+log2(2·WIDTH/LANE). ovfl=0.
- sat_cnt: increments by 1 on each output handshake with ovfl=1 and saturates at all-ones (no wrap). cnt_clr has priority over an increment in the same cycle; the result is 0.
- Stall/flush: op and operands are captured only on an input handshake. Changing A/B/op while not accepted has no effect.
- Simultaneous events: accept and drain in the same cycle are allowed at full rate. Reset asserted mid-stall clears both stages immediately.

Test Plan:
- ADD A=0x7000,B=0x2000 → 2 cycles later S=0x7FFF, ovfl=1, sat_cnt=1; ADD 0x0003+0xFFFE → S=0x0001, ovfl=0.
- SUB A=0x8000,B=0x0001 → S=0x8000, ovfl=1; SUB 0x0005−0x0007 → S=0xFFFE, ovfl=0.
- PADDSB A=0x7812,B=0x1F3F → S=0x7841 (lanes 7+1 sat 7, 8+F sat 8, 1+3=4, 2+F=1), ovfl=1.
- RED A=0x1234,B=0x1111 → S=0x000E; RED A=0x8888,B=0x8888 → S=0xFFC0 (−64), ovfl=0.
- Back-to-back 4 ops with out_ready=0 for 3 cycles mid-stream → in_ready drops after 2 accepted. Outputs must be held stable, then emerge in order with no loss or duplication.
- Assert rst_n=0 with both stages full → out_valid=0 and S=0 immediately. cnt_clr coincident with a saturating output → sat_cnt=0. 256 saturating ops with CNT_W=8 → sat_cnt stays 0xFF.

Source files
------------

// File: rtl/simd_sat_adder_pipe_if.sv
// Operand/result handshake bundle for simd_sat_adder_pipe.
//   in_valid/in_ready : operand-side handshake
//   op, A, B          : operation select and two's-complement operands
//   out_valid/out_ready : result-side handshake
//   S, ovfl           : result and saturation flag
// slave  : the adder side (consumes operands, produces results)
// master : the requester side (drives operands, consumes results)
interface simd_sat_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             ovfl;

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, S, ovfl
  );

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, S, ovfl
  );
endinterface

// File: rtl/simd_sat_adder_pipe.sv
// Two-stage pipelined saturating adder with packed-lane and reduction modes.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : simd_sat_adder_pipe_if.slave (operand and result handshakes)
//   cnt_clr    : synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt    : saturating count of delivered results with ovfl=1
// op: 00 ADD, 01 SUB, 10 PADDSB (lane-wise saturating add), 11 RED (signed lane sum)
module simd_sat_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  simd_sat_adder_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     sat_cnt
);

  localparam int unsigned NL = WIDTH / LANE;
  // Full-precision width of the sum of 2*NL sign-extended lanes
  localparam int unsigned RW = LANE + $clog2(2 * NL);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PADD = 2'b10;

  localparam logic [WIDTH-1:0] MAXV  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAXV = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMINV = {1'b1, {(LANE-1){1'b0}}};

  // Stage-1 payload: raw sums plus the operand signs needed for overflow
  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] raw;   // A+B or A+~B+1
    logic [WIDTH-1:0] psum;  // per-lane sums, no inter-lane carry
    logic [RW-1:0]    red;   // signed sum of all lanes of A and B
    logic             sa;    // A sign
    logic             sb;    // effective B sign (inverted for SUB)
    logic [NL-1:0]    la;    // A lane signs
    logic [NL-1:0]    lb;    // B lane signs
  } s1_t;

  s1_t                s1_d;
  s1_t                s1_q;
  logic               s1_valid;
  logic               s2_valid;
  logic               s1_adv;
  logic               in_ready;
  logic               sub;
  logic [WIDTH-1:0]   bm;
  logic signed [RW-1:0] acc;
  logic [WIDTH-1:0]   res;
  logic               ovf;
  logic               pos;
  logic               neg;
  logic [NL-1:0]      lane_pos;
  logic [NL-1:0]      lane_neg;
  logic [WIDTH-1:0]   s_q;
  logic               ovfl_q;

  // Handshake: stage 2 frees when empty or draining; stage 1 frees when it can move on
  assign s1_adv       = ~s2_valid | bus.out_ready;
  assign in_ready     = ~s1_valid | s1_adv;
  assign bus.in_ready = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.S        = s_q;
  assign bus.ovfl     = ovfl_q;

  // Stage-1 arithmetic
  always_comb begin
    s1_d = '0;
    sub  = (bus.op == OP_SUB);
    bm   = sub ? ~bus.B : bus.B;
    acc  = '0;
    s1_d.op  = bus.op;
    s1_d.raw = bus.A + bm + WIDTH'(sub);
    s1_d.sa  = bus.A[WIDTH-1];
    s1_d.sb  = bm[WIDTH-1];
    for (int i = 0; i < int'(NL); i++) begin
      s1_d.psum[i*LANE +: LANE] = bus.A[i*LANE +: LANE] + bus.B[i*LANE +: LANE];
      s1_d.la[i] = bus.A[i*LANE + LANE - 1];
      s1_d.lb[i] = bus.B[i*LANE + LANE - 1];
      acc = acc + RW'($signed(bus.A[i*LANE +: LANE])) + RW'($signed(bus.B[i*LANE +: LANE]));
    end
    s1_d.red = acc;
  end

  // Stage-1 register: payload captured only on an input handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (bus.in_valid && in_ready) s1_q <= s1_d;
    end
  end

  // Stage-2 saturation / result select
  always_comb begin
    res      = s1_q.raw;
    ovf      = 1'b0;
    pos      = 1'b0;
    neg      = 1'b0;
    lane_pos = '0;
    lane_neg = '0;
    case (s1_q.op)
      OP_ADD, OP_SUB: begin
        pos = ~s1_q.sa & ~s1_q.sb &  s1_q.raw[WIDTH-1];
        neg =  s1_q.sa &  s1_q.sb & ~s1_q.raw[WIDTH-1];
        if (pos)      res = MAXV;
        else if (neg) res = MINV;
        ovf = pos | neg;
      end
      OP_PADD: begin
        res = s1_q.psum;
        for (int i = 0; i < int'(NL); i++) begin
          lane_pos[i] = ~s1_q.la[i] & ~s1_q.lb[i] &  s1_q.psum[i*LANE + LANE - 1];
          lane_neg[i] =  s1_q.la[i] &  s1_q.lb[i] & ~s1_q.psum[i*LANE + LANE - 1];
          if (lane_pos[i])      res[i*LANE +: LANE] = LMAXV;
          else if (lane_neg[i]) res[i*LANE +: LANE] = LMINV;
        end
        ovf = |(lane_pos | lane_neg);
      end
      default: begin
        // RED: sign-extend the full-precision lane sum to the result width
        res = WIDTH'($signed(s1_q.red));
      end
    endcase
  end

  // Stage-2 output register: holds S/ovfl while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s_q      <= '0;
      ovfl_q   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s_q    <= res;
        ovfl_q <= ovf;
      end
    end
  end

  // Saturation-event counter: clear wins, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (s2_valid && bus.out_ready && ovfl_q && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule
